// File: rtl/opsel_pipe.sv
// opsel_pipe: selects one of NIN operand channels, applies an ALU
// operand-conditioning mode, and presents the result through a
// registered valid/ready output backed by a one-entry skid register.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_bus              NIN packed TAM-bit channels, channel k at [k*TAM +: TAM]
//   in_sel              channel select; values >= NIN flag an error
//   in_mode             00 PASS, 01 ONES, 10 ONE, 11 INV
//   in_valid, in_ready  request handshake
//   out_data, out_err   conditioned operand and out-of-range flag
//   out_valid, out_ready result handshake
module opsel_pipe #(
   parameter int TAM  = 16,
   parameter int NIN  = 16,
   parameter int SELW = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NIN*TAM-1:0]  in_bus,
   input  logic [SELW-1:0]     in_sel,
   input  logic [1:0]          in_mode,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [TAM-1:0]      out_data,
   output logic                out_err,
   output logic                out_valid,
   input  logic                out_ready
);

   localparam logic [1:0] MODE_PASS = 2'b00;
   localparam logic [1:0] MODE_ONES = 2'b01;
   localparam logic [1:0] MODE_ONE  = 2'b10;
   localparam logic [1:0] MODE_INV  = 2'b11;

   logic [TAM-1:0] raw;
   logic           raw_err;
   logic [TAM-1:0] cond;

   logic           main_valid_q, main_valid_d;
   logic [TAM-1:0] main_data_q,  main_data_d;
   logic           main_err_q,   main_err_d;
   logic           skid_valid_q, skid_valid_d;
   logic [TAM-1:0] skid_data_q,  skid_data_d;
   logic           skid_err_q,   skid_err_d;
   logic           in_ready_q,   in_ready_d;

   logic           acc;
   logic           drain;
   logic           main_free;

   // Out-of-range selects read as zero so the mode still applies.
   always_comb begin
      raw     = '0;
      raw_err = 1'b1;
      for (int k = 0; k < NIN; k++) begin
         if (int'(in_sel) == k) begin
            raw     = in_bus[k*TAM +: TAM];
            raw_err = 1'b0;
         end
      end
   end

   always_comb begin
      cond = raw;
      unique case (in_mode)
         MODE_PASS: cond = raw;
         MODE_ONES: cond = '1;
         MODE_ONE:  cond = TAM'(1);
         MODE_INV:  cond = ~raw;
      endcase
   end

   assign acc       = in_valid && in_ready;
   assign drain     = main_valid_q && out_ready;
   assign main_free = !main_valid_q || drain;

   always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      main_err_d   = main_err_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_err_d   = skid_err_q;

      if (main_free) begin
         if (skid_valid_q) begin
            // Older skid beat goes first; a new beat takes its place.
            main_valid_d = 1'b1;
            main_data_d  = skid_data_q;
            main_err_d   = skid_err_q;
            skid_valid_d = acc;
            if (acc) begin
               skid_data_d = cond;
               skid_err_d  = raw_err;
            end
         end else begin
            main_valid_d = acc;
            if (acc) begin
               main_data_d = cond;
               main_err_d  = raw_err;
            end
         end
      end else if (acc) begin
         skid_valid_d = 1'b1;
         skid_data_d  = cond;
         skid_err_d   = raw_err;
      end

      in_ready_d = !skid_valid_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         main_data_q  <= '0;
         main_err_q   <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_err_q   <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         main_err_q   <= main_err_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_err_q   <= skid_err_d;
         in_ready_q   <= in_ready_d;
      end
   end

   // Gating with rst keeps the block closed during the reset cycle.
   assign in_ready  = in_ready_q && !rst;
   assign out_valid = main_valid_q;
   assign out_data  = main_data_q;
   assign out_err   = main_err_q;

endmodule

// File: tb/tb_opsel_pipe.sv
// Directed and randomized checks for opsel_pipe (NIN=16 and NIN=12).
// Ports of both instances are driven from this bench.
module tb_opsel_pipe;

   logic clk;
   logic rst;

   logic [255:0] bus16;
   logic [3:0]   sel16;
   logic [1:0]   mode16;
   logic         iv16;
   logic         ir16;
   logic [15:0]  od16;
   logic         oe16;
   logic         ov16;
   logic         or16;

   logic [191:0] bus12;
   logic [3:0]   sel12;
   logic [1:0]   mode12;
   logic         iv12;
   logic         ir12;
   logic [15:0]  od12;
   logic         oe12;
   logic         ov12;
   logic         or12;

   int tests;
   int fails;

   opsel_pipe #(.TAM(16), .NIN(16), .SELW(4)) u16 (
      .clk(clk), .rst(rst),
      .in_bus(bus16), .in_sel(sel16), .in_mode(mode16),
      .in_valid(iv16), .in_ready(ir16),
      .out_data(od16), .out_err(oe16),
      .out_valid(ov16), .out_ready(or16)
   );

   opsel_pipe #(.TAM(16), .NIN(12), .SELW(4)) u12 (
      .clk(clk), .rst(rst),
      .in_bus(bus12), .in_sel(sel12), .in_mode(mode12),
      .in_valid(iv12), .in_ready(ir12),
      .out_data(od12), .out_err(oe12),
      .out_valid(ov12), .out_ready(or12)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] f_cond(input logic [15:0] r,
                                          input logic [1:0] m);
      case (m)
         2'b00:   return r;
         2'b01:   return 16'hFFFF;
         2'b10:   return 16'h0001;
         default: return ~r;
      endcase
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      step();
      tests++;
      if (ov16 !== 1'b0 || od16 !== 16'h0 || oe16 !== 1'b0) begin
         fails++;
         $display("FAIL reset_out: v=%b d=%h e=%b want 0 0000 0",
                  ov16, od16, oe16);
      end
      tests++;
      if (ir16 !== 1'b0) begin
         fails++;
         $display("FAIL reset_ready_in_rst: got %b want 0", ir16);
      end
      rst = 1'b0;
      #1;
      tests++;
      if (ir16 !== 1'b1 || ir12 !== 1'b1) begin
         fails++;
         $display("FAIL reset_ready_after: got %b/%b want 1/1", ir16, ir12);
      end
   endtask

   task automatic test_pass();
      or16 = 1'b1;
      bus16[5*16 +: 16] = 16'h1234;
      sel16 = 4'd5;
      mode16 = 2'b00;
      iv16 = 1'b1;
      step();
      iv16 = 1'b0;
      tests++;
      if (ov16 !== 1'b1 || od16 !== 16'h1234 || oe16 !== 1'b0) begin
         fails++;
         $display("FAIL pass: v=%b d=%h e=%b want 1 1234 0", ov16, od16, oe16);
      end
      step();
      tests++;
      if (ov16 !== 1'b0) begin
         fails++;
         $display("FAIL pass_one_cycle: v=%b want 0", ov16);
      end
   endtask

   task automatic test_modes();
      logic [15:0] exp_v [3];
      logic [1:0]  md    [3];
      exp_v[0] = 16'hFFFF; md[0] = 2'b01;
      exp_v[1] = 16'h0001; md[1] = 2'b10;
      exp_v[2] = 16'hFF0F; md[2] = 2'b11;
      or16 = 1'b1;
      bus16[3*16 +: 16] = 16'h00F0;
      sel16 = 4'd3;
      mode16 = md[0];
      iv16 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         if (i < 2) mode16 = md[i+1];
         else iv16 = 1'b0;
         tests++;
         if (ov16 !== 1'b1 || od16 !== exp_v[i] || oe16 !== 1'b0) begin
            fails++;
            $display("FAIL modes[%0d]: v=%b d=%h e=%b want 1 %h 0",
                     i, ov16, od16, oe16, exp_v[i]);
         end
      end
      step();
      tests++;
      if (ov16 !== 1'b0) begin
         fails++;
         $display("FAIL modes_end: v=%b want 0", ov16);
      end
   endtask

   task automatic test_out_of_range();
      logic [3:0]  s   [4];
      logic [1:0]  m   [4];
      logic [15:0] ed  [4];
      logic        ee  [4];
      s[0] = 4'd13; m[0] = 2'b00; ed[0] = 16'h0000; ee[0] = 1'b1;
      s[1] = 4'd13; m[1] = 2'b11; ed[1] = 16'hFFFF; ee[1] = 1'b1;
      s[2] = 4'd12; m[2] = 2'b00; ed[2] = 16'h0000; ee[2] = 1'b1;
      s[3] = 4'd11; m[3] = 2'b00; ed[3] = 16'hABCD; ee[3] = 1'b0;
      or12 = 1'b1;
      bus12 = {192{1'b1}};
      bus12[11*16 +: 16] = 16'hABCD;
      iv12 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sel12 = s[i];
         mode12 = m[i];
         step();
         tests++;
         if (ov12 !== 1'b1 || od12 !== ed[i] || oe12 !== ee[i]) begin
            fails++;
            $display("FAIL oor[%0d]: v=%b d=%h e=%b want 1 %h %b",
                     i, ov12, od12, oe12, ed[i], ee[i]);
         end
      end
      iv12 = 1'b0;
      step();
   endtask

   task automatic test_skid();
      bus16[0*16 +: 16] = 16'h0011;
      bus16[1*16 +: 16] = 16'h0022;
      bus16[2*16 +: 16] = 16'h0033;
      mode16 = 2'b00;
      or16 = 1'b0;
      sel16 = 4'd0;
      iv16 = 1'b1;
      step();
      sel16 = 4'd1;
      step();
      tests++;
      if (ov16 !== 1'b1 || od16 !== 16'h0011 || ir16 !== 1'b0) begin
         fails++;
         $display("FAIL skid_fill: v=%b d=%h rdy=%b want 1 0011 0",
                  ov16, od16, ir16);
      end
      sel16 = 4'd2;
      step();
      tests++;
      if (ov16 !== 1'b1 || od16 !== 16'h0011 || ir16 !== 1'b0) begin
         fails++;
         $display("FAIL skid_hold: v=%b d=%h rdy=%b want 1 0011 0",
                  ov16, od16, ir16);
      end
      or16 = 1'b1;
      step();
      tests++;
      if (ov16 !== 1'b1 || od16 !== 16'h0022 || ir16 !== 1'b1) begin
         fails++;
         $display("FAIL skid_b: v=%b d=%h rdy=%b want 1 0022 1",
                  ov16, od16, ir16);
      end
      step();
      iv16 = 1'b0;
      tests++;
      if (ov16 !== 1'b1 || od16 !== 16'h0033) begin
         fails++;
         $display("FAIL skid_c: v=%b d=%h want 1 0033", ov16, od16);
      end
      step();
      tests++;
      if (ov16 !== 1'b0) begin
         fails++;
         $display("FAIL skid_end: v=%b want 0", ov16);
      end
   endtask

   task automatic test_reset_full();
      bus16[0*16 +: 16] = 16'h0AAA;
      bus16[1*16 +: 16] = 16'h0BBB;
      mode16 = 2'b00;
      or16 = 1'b0;
      sel16 = 4'd0;
      iv16 = 1'b1;
      step();
      sel16 = 4'd1;
      step();
      iv16 = 1'b0;
      tests++;
      if (ir16 !== 1'b0 || ov16 !== 1'b1) begin
         fails++;
         $display("FAIL rstfull_pre: rdy=%b v=%b want 0 1", ir16, ov16);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      tests++;
      if (ov16 !== 1'b0 || od16 !== 16'h0 || ir16 !== 1'b1) begin
         fails++;
         $display("FAIL rstfull_post: v=%b d=%h rdy=%b want 0 0000 1",
                  ov16, od16, ir16);
      end
      or16 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         tests++;
         if (ov16 !== 1'b0) begin
            fails++;
            $display("FAIL rstfull_ghost[%0d]: v=%b d=%h want v=0",
                     i, ov16, od16);
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] q[$];
      logic [15:0] e;
      int          acc_n;
      int          cyc;
      acc_n = 0;
      cyc = 0;
      iv16 = 1'b0;
      or16 = 1'b0;
      while (acc_n < 1000 && cyc < 20000) begin
         iv16 = 1'($urandom_range(0, 1));
         or16 = 1'($urandom_range(0, 1));
         sel16 = 4'($urandom_range(0, 15));
         mode16 = 2'($urandom_range(0, 3));
         for (int k = 0; k < 16; k++) bus16[k*16 +: 16] = 16'($urandom);
         #1;
         if (ov16 && or16) begin
            tests++;
            if (q.size() == 0) begin
               fails++;
               $display("FAIL rand_dup: unexpected beat d=%h", od16);
            end else begin
               e = q.pop_front();
               if (od16 !== e || oe16 !== 1'b0) begin
                  fails++;
                  $display("FAIL rand_data: d=%h e=%b want %h 0",
                           od16, oe16, e);
               end
            end
         end
         if (iv16 && ir16) begin
            q.push_back(f_cond(bus16[sel16*16 +: 16], mode16));
            acc_n++;
         end
         step();
         cyc++;
      end
      tests++;
      if (acc_n < 1000) begin
         fails++;
         $display("FAIL rand_timeout: accepted %0d want 1000", acc_n);
      end
      iv16 = 1'b0;
      or16 = 1'b1;
      cyc = 0;
      while (cyc < 10) begin
         #1;
         if (ov16) begin
            tests++;
            if (q.size() == 0) begin
               fails++;
               $display("FAIL rand_dup_drain: d=%h", od16);
            end else begin
               e = q.pop_front();
               if (od16 !== e) begin
                  fails++;
                  $display("FAIL rand_drain: d=%h want %h", od16, e);
               end
            end
         end
         step();
         cyc++;
      end
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL rand_loss: %0d beats missing want 0", q.size());
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b1;
      bus16 = '0; sel16 = '0; mode16 = '0; iv16 = 1'b0; or16 = 1'b1;
      bus12 = '0; sel12 = '0; mode12 = '0; iv12 = 1'b0; or12 = 1'b1;
      #2;
      test_reset();
      test_pass();
      test_modes();
      test_out_of_range();
      test_skid();
      test_reset_full();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
